// File: rtl/cam_capture_ctrl.sv
// Camera stream capture controller: frames a dual-pixel FVAL/LVAL/DVAL stream into
// linear frame-buffer writes, with single/continuous modes and geometry checking.
module cam_capture_ctrl #(
  parameter int unsigned PIXEL_WIDTH = 8,
  parameter int unsigned H_ACTIVE    = 640,
  parameter int unsigned V_ACTIVE    = 480,
  parameter int unsigned ADDR_WIDTH  = 19
) (
  input  logic                     CLK,
  input  logic                     RST,
  input  logic                     iSTART,
  input  logic                     iSINGLE,
  input  logic                     iSTOP,
  input  logic                     iABORT,
  input  logic                     iFVAL,
  input  logic                     iLVAL,
  input  logic                     iDVAL,
  input  logic [PIXEL_WIDTH-1:0]   iDATA_L,
  input  logic [PIXEL_WIDTH-1:0]   iDATA_R,
  output logic                     oWR_EN,
  output logic [ADDR_WIDTH-1:0]    oWR_ADDR,
  output logic [2*PIXEL_WIDTH-1:0] oWR_DATA,
  output logic                     oBUSY,
  output logic                     oFRAME_DONE,
  output logic                     oERR_LINE,
  output logic                     oERR_FRAME,
  output logic [15:0]              oFRAME_CNT
);

  localparam int unsigned PIX_W  = $clog2(H_ACTIVE + 1);
  localparam int unsigned LINE_W = $clog2(V_ACTIVE + 2);
  localparam logic [PIX_W-1:0]      PIX_MAX   = PIX_W'(H_ACTIVE);
  localparam logic [LINE_W-1:0]     LINE_MAX  = LINE_W'(V_ACTIVE);
  localparam logic [LINE_W-1:0]     LINE_SAT  = LINE_W'(V_ACTIVE + 1);
  localparam logic [ADDR_WIDTH-1:0] LINE_STEP = ADDR_WIDTH'(H_ACTIVE);

  typedef enum logic [1:0] {IDLE, WAIT_SOF, CAPTURE} state_t;

  state_t                  state;
  logic                    fval_d;
  logic                    lval_d;
  logic                    single;
  logic                    stop_pend;
  logic [PIX_W-1:0]        pix_cnt;
  logic [LINE_W-1:0]       line_cnt;
  logic [ADDR_WIDTH-1:0]   line_base;

  logic sof, eof, eol, beat, accept, overflow;
  logic [LINE_W-1:0] line_next;

  assign sof  = iFVAL & ~fval_d;
  assign eof  = ~iFVAL & fval_d;
  assign eol  = ~iLVAL & lval_d;
  assign beat = iFVAL & iLVAL & iDVAL;

  assign accept   = (state == CAPTURE) && beat && (pix_cnt < PIX_MAX) && (line_cnt < LINE_MAX);
  assign overflow = (state == CAPTURE) && beat && (pix_cnt == PIX_MAX) && (line_cnt < LINE_MAX);

  // Line count as it stands after this cycle's EOL, so a coincident EOF sees it.
  assign line_next = !eol ? line_cnt :
                     (line_cnt == LINE_SAT) ? line_cnt : line_cnt + LINE_W'(1);

  always_ff @(posedge CLK) begin
    if (RST) begin
      state       <= IDLE;
      fval_d      <= 1'b1;
      lval_d      <= 1'b1;
      single      <= 1'b0;
      stop_pend   <= 1'b0;
      pix_cnt     <= '0;
      line_cnt    <= '0;
      line_base   <= '0;
      oWR_EN      <= 1'b0;
      oWR_ADDR    <= '0;
      oWR_DATA    <= '0;
      oBUSY       <= 1'b0;
      oFRAME_DONE <= 1'b0;
      oERR_LINE   <= 1'b0;
      oERR_FRAME  <= 1'b0;
      oFRAME_CNT  <= '0;
    end else begin
      fval_d      <= iFVAL;
      lval_d      <= iLVAL;
      oFRAME_DONE <= 1'b0;
      // A beat accepted in an abort cycle still produces its write.
      oWR_EN      <= accept;
      if (accept) begin
        oWR_ADDR <= line_base + ADDR_WIDTH'(pix_cnt);
        oWR_DATA <= {iDATA_L, iDATA_R};
      end

      if (iABORT) begin
        state     <= IDLE;
        oBUSY     <= 1'b0;
        stop_pend <= 1'b0;
      end else begin
        case (state)
          IDLE: begin
            if (iSTART) begin
              state      <= WAIT_SOF;
              oBUSY      <= 1'b1;
              single     <= iSINGLE;
              oERR_LINE  <= 1'b0;
              oERR_FRAME <= 1'b0;
            end
          end
          WAIT_SOF: begin
            if (iSTOP) begin
              state     <= IDLE;
              oBUSY     <= 1'b0;
              stop_pend <= 1'b0;
            end else if (sof) begin
              state     <= CAPTURE;
              pix_cnt   <= '0;
              line_cnt  <= '0;
              line_base <= '0;
            end
          end
          CAPTURE: begin
            if (accept) pix_cnt <= pix_cnt + PIX_W'(1);
            if (overflow) oERR_LINE <= 1'b1;
            if (iSTOP) stop_pend <= 1'b1;
            if (eol) begin
              if ((pix_cnt != PIX_MAX) && (line_cnt < LINE_MAX)) oERR_LINE <= 1'b1;
              line_cnt  <= line_next;
              line_base <= line_base + LINE_STEP;
              pix_cnt   <= '0;
            end
            if (eof) begin
              if (line_next != LINE_MAX) oERR_FRAME <= 1'b1;
              oFRAME_DONE <= 1'b1;
              oFRAME_CNT  <= oFRAME_CNT + 16'd1;
              if (single || stop_pend || iSTOP) begin
                state     <= IDLE;
                oBUSY     <= 1'b0;
                stop_pend <= 1'b0;
              end else begin
                state <= WAIT_SOF;
              end
            end
          end
          default: begin
            state <= IDLE;
            oBUSY <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule
